// File: rtl/negate_serial.sv
// negate_serial: digit-serial two's-complement sign unit.
// Four modes: pass, ones-complement, negate and abs. The datapath handles
// CHUNK bits per busy cycle. Input and output use valid/ready handshakes,
// and a sticky flag records any overflowed result that was delivered.
module negate_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [1:0]       r_m;
  logic             r_inv;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_res;

  logic [CHUNK-1:0] w_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic             w_deliver;
  logic             w_in_neg;
  logic             w_ovf_calc;

  assign in_ready   = (r_state == IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_deliver  = out_valid && out_ready;
  assign w_in_neg   = in_data[WIDTH-1];
  // Only negate/abs of the most-negative value cannot be represented.
  assign w_ovf_calc = r_m[1] && (r_a == MOST_NEG);

  // One chunk of the conditional-invert-plus-carry add, merged into the result.
  always_comb begin
    w_chunk    = r_a[r_idx*CHUNK +: CHUNK];
    w_sum      = {1'b0, (r_inv ? ~w_chunk : w_chunk)} + {{CHUNK{1'b0}}, r_carry};
    w_res_next = r_res;
    w_res_next[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end

  // Control FSM, serial datapath registers, and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_m        <= '0;
      r_inv      <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_res      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      // A set at delivery takes priority over a clear in the same cycle.
      if (w_deliver && overflow) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= in_data;
            r_m     <= mode;
            r_idx   <= '0;
            r_inv   <= (mode == 2'b01) || (mode == 2'b10) ||
                       ((mode == 2'b11) && w_in_neg);
            r_carry <= (mode == 2'b10) || ((mode == 2'b11) && w_in_neg);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_res   <= w_res_next;
          r_carry <= w_sum[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            // The final carry-out is dropped; overflow comes from the operand.
            out_data  <= w_res_next;
            overflow  <= w_ovf_calc;
            out_valid <= 1'b1;
            r_idx     <= '0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_negate_serial.sv
// tb_negate_serial: checks three negate_serial configurations (16/4, 8/8, 32/2)
// against an arithmetic reference model, plus directed literal vectors.
`timescale 1ns/1ps
module tb_negate_serial;

  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid   [NL];
  logic        out_ready  [NL];
  logic        ovf_clr    [NL];
  logic [63:0] in_data    [NL];
  logic [1:0]  mode       [NL];
  logic        in_ready   [NL];
  logic        out_valid  [NL];
  logic        overflow   [NL];
  logic        ovf_sticky [NL];
  logic [63:0] out_data   [NL];

  int checks = 0;
  int errors = 0;

  function automatic int lw(int g);
    return (g == 0) ? 16 : ((g == 1) ? 8 : 32);
  endfunction

  function automatic int lc(int g);
    return (g == 0) ? 4 : ((g == 1) ? 8 : 2);
  endfunction

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int W = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    localparam int C = (g == 0) ? 4 : ((g == 1) ? 8 : 2);
    logic [W-1:0] w_out;
    logic         w_ir, w_ov, w_of, w_st;
    negate_serial #(.WIDTH(W), .CHUNK(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (w_ir),
      .in_data    (in_data[g][W-1:0]),
      .mode       (mode[g]),
      .out_valid  (w_ov),
      .out_ready  (out_ready[g]),
      .out_data   (w_out),
      .overflow   (w_of),
      .ovf_sticky (w_st),
      .ovf_clr    (ovf_clr[g])
    );
    assign in_ready[g]   = w_ir;
    assign out_valid[g]  = w_ov;
    assign overflow[g]   = w_of;
    assign ovf_sticky[g] = w_st;
    assign out_data[g]   = 64'(w_out);
  end

  // Reference model: plain two's-complement arithmetic on a masked 64-bit value.
  function automatic logic [63:0] mask_of(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] model_res(int w, logic [63:0] a, logic [1:0] m);
    logic [63:0] x;
    logic [63:0] msk;
    msk = mask_of(w);
    x   = a & msk;
    case (m)
      2'b00:   return x;
      2'b01:   return ~x & msk;
      2'b10:   return (64'd0 - x) & msk;
      default: return x[w-1] ? ((64'd0 - x) & msk) : x;
    endcase
  endfunction

  function automatic logic model_ovf(int w, logic [63:0] a, logic [1:0] m);
    return m[1] && ((a & mask_of(w)) == (64'd1 << (w - 1)));
  endfunction

  task automatic chk(string name, int g, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d t=%0t actual=%h required=%h", name, g, $time, act, exp);
    end
  endtask

  // Scoreboard: one outstanding expectation per lane, captured at acceptance.
  logic        pend    [NL];
  logic [63:0] exp_d   [NL];
  logic        exp_o   [NL];
  int          acc_cyc [NL];
  logic        prev_ov [NL];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NL; g++) begin
      if (rst) begin
        pend[g] <= 1'b0;
      end else if (in_valid[g] && in_ready[g]) begin
        pend[g]    <= 1'b1;
        exp_d[g]   <= model_res(lw(g), in_data[g], mode[g]);
        exp_o[g]   <= model_ovf(lw(g), in_data[g], mode[g]);
        acc_cyc[g] <= cyc;
      end else if (out_valid[g] && out_ready[g]) begin
        pend[g] <= 1'b0;
      end
    end
  end

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    for (int g = 0; g < NL; g++) begin
      if (!rst && out_valid[g]) begin
        if (!pend[g]) begin
          chk("spurious_result", g, {63'd0, out_valid[g]}, 64'd0);
        end else begin
          chk("model_data", g, out_data[g], exp_d[g]);
          chk("model_ovf", g, {63'd0, overflow[g]}, {63'd0, exp_o[g]});
          if (!prev_ov[g])
            chk("latency", g, 64'(cyc - acc_cyc[g] - 1), 64'(lw(g) / lc(g)));
        end
      end
      prev_ov[g] <= rst ? 1'b0 : out_valid[g];
    end
  end

  task automatic send(int g, logic [63:0] d, logic [1:0] m);
    int n;
    n = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    mode[g]     = m;
    while (!in_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", g, {63'd0, in_ready[g]}, 64'd1);
    @(negedge clk);
    in_valid[g] = 1'b0;
    in_data[g]  = ~d;
    mode[g]     = ~m;
  endtask

  task automatic recv(int g, output logic [63:0] d, output logic o);
    int n;
    n = 0;
    while (!out_valid[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("result_arrives", g, {63'd0, out_valid[g]}, 64'd1);
    d = out_data[g];
    o = overflow[g];
    @(negedge clk);
  endtask

  task automatic xact(int g, logic [63:0] d, logic [1:0] m, logic [63:0] ed, logic eo);
    logic [63:0] rd;
    logic        ro;
    send(g, d, m);
    recv(g, rd, ro);
    chk("literal_data", g, rd, ed);
    chk("literal_ovf", g, {63'd0, ro}, {63'd0, eo});
  endtask

  task automatic drain(int g, logic [63:0] d, logic [1:0] m);
    logic [63:0] rd;
    logic        ro;
    send(g, d, m);
    recv(g, rd, ro);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    int          n;
    for (int g = 0; g < NL; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      ovf_clr[g]   = 1'b0;
      in_data[g]   = '0;
      mode[g]      = 2'b00;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 0, {63'd0, out_valid[0]}, 64'd0);
    chk("rst_in_ready", 0, {63'd0, in_ready[0]}, 64'd0);
    chk("rst_out_data", 0, out_data[0], 64'd0);
    chk("rst_overflow", 0, {63'd0, overflow[0]}, 64'd0);
    chk("rst_sticky", 0, {63'd0, ovf_sticky[0]}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 0, {63'd0, in_ready[0]}, 64'd1);
    @(negedge clk);

    // Negate, overflow, abs, ones-complement, pass at defaults
    xact(0, 64'h0001, 2'b10, 64'hFFFF, 1'b0);
    xact(0, 64'h7FFF, 2'b10, 64'h8001, 1'b0);
    chk("sticky_clean", 0, {63'd0, ovf_sticky[0]}, 64'd0);
    xact(0, 64'h8000, 2'b10, 64'h8000, 1'b1);
    chk("sticky_set", 0, {63'd0, ovf_sticky[0]}, 64'd1);
    xact(0, 64'h8000, 2'b11, 64'h8000, 1'b1);
    chk("sticky_set_abs", 0, {63'd0, ovf_sticky[0]}, 64'd1);
    xact(0, 64'hFFF6, 2'b11, 64'h000A, 1'b0);
    xact(0, 64'h0005, 2'b11, 64'h0005, 1'b0);
    xact(0, 64'h00FF, 2'b01, 64'hFF00, 1'b0);
    xact(0, 64'h1234, 2'b00, 64'h1234, 1'b0);
    xact(0, 64'h8000, 2'b00, 64'h8000, 1'b0);
    xact(0, 64'h8000, 2'b01, 64'h7FFF, 1'b0);

    // Sticky clear, then set-wins-over-clear at an overflowed delivery
    ovf_clr[0] = 1'b1;
    @(negedge clk);
    chk("sticky_cleared", 0, {63'd0, ovf_sticky[0]}, 64'd0);
    ovf_clr[0] = 1'b0;
    xact(0, 64'h0000, 2'b10, 64'h0000, 1'b0);
    chk("sticky_stays_clear", 0, {63'd0, ovf_sticky[0]}, 64'd0);
    ovf_clr[0] = 1'b1;
    xact(0, 64'h8000, 2'b10, 64'h8000, 1'b1);
    chk("sticky_set_wins", 0, {63'd0, ovf_sticky[0]}, 64'd1);
    ovf_clr[0] = 1'b0;

    // Backpressure: result held, new operand ignored while DONE
    out_ready[0] = 1'b0;
    send(0, 64'h0003, 2'b10);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid[0] = 1'b1;
    in_data[0]  = 64'h0005;
    mode[0]     = 2'b00;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 0, {63'd0, out_valid[0]}, 64'd1);
      chk("bp_data", 0, out_data[0], 64'hFFFD);
      chk("bp_in_ready", 0, {63'd0, in_ready[0]}, 64'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_released", 0, {63'd0, out_valid[0]}, 64'd0);
    chk("bp_idle", 0, {63'd0, in_ready[0]}, 64'd1);

    // Reset while chunk 2 is being processed
    send(0, 64'h0001, 2'b10);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 0, {63'd0, out_valid[0]}, 64'd0);
    chk("midrst_idle", 0, {63'd0, in_ready[0]}, 64'd1);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_result", 0, {63'd0, out_valid[0]}, 64'd0);
    end
    xact(0, 64'h0002, 2'b10, 64'hFFFE, 1'b0);

    // Parameter sweep: literal pins, corner operands, random operands
    xact(1, 64'h80, 2'b11, 64'h80, 1'b1);
    xact(1, 64'hF6, 2'b11, 64'h0A, 1'b0);
    xact(1, 64'h01, 2'b10, 64'hFF, 1'b0);
    xact(2, 64'h00000001, 2'b10, 64'hFFFFFFFF, 1'b0);
    xact(2, 64'h80000000, 2'b10, 64'h80000000, 1'b1);
    xact(2, 64'h12345678, 2'b01, 64'hEDCBA987, 1'b0);
    xact(2, 64'hFFFFFFF6, 2'b11, 64'h0000000A, 1'b0);
    for (int g = 0; g < NL; g++) begin
      for (int unsigned m = 0; m < 4; m++) begin
        drain(g, 64'd0, 2'(m));
        drain(g, mask_of(lw(g)), 2'(m));
        drain(g, 64'd1 << (lw(g) - 1), 2'(m));
        drain(g, (64'd1 << (lw(g) - 1)) - 64'd1, 2'(m));
        drain(g, (64'd1 << (lw(g) - 1)) + 64'd1, 2'(m));
      end
      for (int i = 0; i < 12; i++) begin
        d = {32'($urandom), 32'($urandom)} & mask_of(lw(g));
        drain(g, d, 2'($urandom_range(0, 3)));
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/negate_serial.md
Name: negate_serial

Overview:
- Parametrised, multi-cycle two's-complement sign-operation unit.
- Generalises the fixed 16-bit combinational negator: configurable width, digit-serial datapath processing CHUNK bits per cycle, four operation modes, valid/ready handshakes on input and output, and a sticky overflow status.
- Sits between operand sources and the ALU datapath wherever negate, absolute value or complement is needed without a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits. Legal when WIDTH >= 2.
- CHUNK, 4, bits processed per busy cycle. WIDTH % CHUNK == 0 is required. CHUNK == WIDTH gives a single busy cycle.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/mode valid.
- in_ready  out  1  unit can accept an operand. Equals (state==IDLE) && !rst.
- in_data  in  WIDTH  signed operand.
- mode  in  2  operation: 00 pass, 01 ones-complement, 10 negate, 11 abs.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- overflow  out  1  result overflowed. Valid while out_valid is high.
- ovf_sticky  out  1  set by any delivered overflowed result.
- ovf_clr  in  1  clears ovf_sticky.

Behaviour:
- Reset (rst high at an edge):
  - state := IDLE.
  - out_valid, out_data, overflow, ovf_sticky := 0. Internal operand/carry/chunk index := 0.
  - Reset mid-operation abandons the operation; no result is produced.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_valid && in_ready: latch in_data and mode into registers A and M, chunk index := 0, then go to BUSY.
  - Latched at that edge:
    - inv := (M==01) || (M==10) || (M==11 && A[WIDTH-1]).
    - carry := (M==10) || (M==11 && A[WIDTH-1]).
- BUSY, N = WIDTH/CHUNK cycles, chunk k taken from the LSB upward:
  - r_k = (inv ? ~A[k] : A[k]) + carry. This is an unsigned CHUNK+1-bit sum.
  - Store the low CHUNK bits into result chunk k. carry := bit CHUNK of r_k.
  - After chunk N-1: out_data := result, overflow := ovf_calc, go to DONE with out_valid=1.
- ovf_calc: 1 iff M is 10 or 11 and A == {1'b1,{WIDTH-1{1'b0}}}. The result is then the same most-negative pattern. Pass and ones-complement never overflow.
- Final carry-out is discarded; it does not indicate overflow.
- DONE:
  - out_valid=1. out_data and overflow are held stable until out_valid && out_ready.
  - On handshake: out_valid := 0, go to IDLE.
  - in_ready stays 0 in BUSY and DONE. in_valid is ignored there; the operand must be held by the source.
- Latency:
  - Input handshake at edge T → out_valid high after edge T+N. N=4 at defaults.
  - Minimum initiation interval is N+2 cycles when out_ready is held high.
- ovf_sticky:
  - Set at the output handshake edge when overflow=1.
  - ovf_clr clears it. If set and clear occur at the same edge, set wins.
- A change of in_data or mode after acceptance has no effect on the operation in flight.

Test Plan:
- Negate at defaults: mode=10, in_data=16'h0001 → 4 cycles later out_data=16'hFFFF, overflow=0. Then 16'h7FFF → 16'h8001.
- Overflow and sticky: mode=10, in_data=16'h8000 → out_data=16'h8000, overflow=1, ovf_sticky=1 after handshake. Then mode=11, in_data=16'h8000 → same result and flags.
- Abs and ones-complement:
  - mode=11, 16'hFFF6 → 16'h000A.
  - mode=11, 16'h0005 → 16'h0005.
  - mode=01, 16'h00FF → 16'hFF00.
  - mode=00, 16'h1234 → 16'h1234.
  - overflow=0 in every case.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_data/out_valid held stable, in_ready=0, a new in_valid is ignored. Raising out_ready gives one handshake, then IDLE.
- Reset mid-op: assert rst during BUSY chunk 2 → next cycle out_valid=0 and state IDLE, with no spurious result. Asserting ovf_clr together with an overflowed delivery leaves ovf_sticky=1.
- Parameter sweep: WIDTH=8/CHUNK=8 (1 busy cycle) and WIDTH=32/CHUNK=2 (16 busy cycles), random operands in all modes → results match the two's-complement reference model, and latency equals WIDTH/CHUNK.
